fpsubtractor: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing `result = op1 - op2`, the inverse-operation companion to the `fpadder` datapath. It captures operands on a `start` pulse and walks a fixed-latency align/add/normalize/round pipeline under one FSM. It reports completion with a one-cycle `done` pulse. It sits beside the adder in the FP arithmetic cluster and shares its `op1`/`op2`/`result`/`busy`/`done` interface.

---
 rtl/fpsubtractor.sv | 234 +++++++++++++++++++++++
 tb/tb_fpsubtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpsubtractor.sv
`default_nettype none
// ============================================================================
// Module   : fpsubtractor
// Purpose  : Multi-cycle IEEE-754 binary32 subtractor, result = op1 - op2.
//            Operands are captured on a start pulse in IDLE and pass through
//            ALIGN -> ADDSUB -> NORM -> ROUND -> DONE. The latency is fixed
//            for every operand class. Round to nearest, ties to even.
//            Denormal inputs and underflowing results are flushed to signed
//            zero.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-low reset
//            start  - operation request, sampled only in IDLE
//            op1    - minuend (binary32)
//            op2    - subtrahend (binary32)
//            result - difference, registered, held until the next result
//            busy   - registered, high for the 4 cycles before done
//            done   - registered one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module fpsubtractor (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0]  c_st_idle   = 3'd0;
  localparam logic [2:0]  c_st_align  = 3'd1;
  localparam logic [2:0]  c_st_addsub = 3'd2;
  localparam logic [2:0]  c_st_norm   = 3'd3;
  localparam logic [2:0]  c_st_round  = 3'd4;
  localparam logic [2:0]  c_st_done   = 3'd5;
  localparam logic [31:0] c_qnan      = 32'h7FC0_0000;
  localparam logic [30:0] c_inf_mag   = 31'h7F80_0000;

  logic [2:0]        r_state, w_next_state;
  logic [31:0]       r_x, r_y;           // r_y carries the negated op2
  logic              r_special;
  logic [31:0]       r_special_val;
  logic [26:0]       r_sig_a, r_sig_b;   // {hidden, 23 frac, G, R, S}
  logic [7:0]        r_exp;
  logic              r_sign, r_eff_sub;
  logic [27:0]       r_sum;
  logic              r_sum_zero;
  logic [25:0]       r_norm;             // {23 frac, G, R, S}, hidden bit implied
  logic signed [9:0] r_nexp;
  logic              r_nzero;
  logic [31:0]       r_final;

  // ---------------- classification of the captured operands ----------------
  logic [31:0] w_op2n;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_spec;
  logic [31:0] w_spec_val;

  always_comb begin
    w_op2n   = {~op2[31], op2[30:0]};
    w_a_zero = (op1[30:23] == 8'd0);
    w_b_zero = (op2[30:23] == 8'd0);
    w_a_inf  = (op1[30:23] == 8'hFF) && (op1[22:0] == 23'd0);
    w_b_inf  = (op2[30:23] == 8'hFF) && (op2[22:0] == 23'd0);
    w_a_nan  = (op1[30:23] == 8'hFF) && (op1[22:0] != 23'd0);
    w_b_nan  = (op2[30:23] == 8'hFF) && (op2[22:0] != 23'd0);
    w_spec     = 1'b1;
    w_spec_val = 32'd0;
    if (w_a_nan || w_b_nan)
      w_spec_val = c_qnan;
    else if (w_a_inf && w_b_inf)
      // infinities of opposite sign after negation cancel to NaN
      w_spec_val = (op1[31] == w_op2n[31]) ? {op1[31], c_inf_mag} : c_qnan;
    else if (w_a_inf)
      w_spec_val = {op1[31], c_inf_mag};
    else if (w_b_inf)
      w_spec_val = {w_op2n[31], c_inf_mag};
    else if (w_a_zero && w_b_zero)
      w_spec_val = {op1[31] & w_op2n[31], 31'd0};
    else if (w_a_zero)
      w_spec_val = w_op2n;
    else if (w_b_zero)
      w_spec_val = op1;
    else
      w_spec = 1'b0;
  end

  // ---------------- ALIGN: order by magnitude, shift the smaller ----------------
  logic        w_swap;
  logic [31:0] w_big, w_small;
  logic [7:0]  w_d;
  logic [26:0] w_sig_b, w_b_shift, w_mask, w_b_aligned;

  always_comb begin
    w_swap    = (r_y[30:0] > r_x[30:0]);
    w_big     = w_swap ? r_y : r_x;
    w_small   = w_swap ? r_x : r_y;
    w_d       = w_big[30:23] - w_small[30:23];
    w_sig_b   = {1'b1, w_small[22:0], 3'b000};
    w_b_shift = 27'd0;
    w_mask    = 27'd0;
    if (w_d >= 8'd27) begin
      w_b_aligned = 27'd1;
    end else begin
      w_b_shift   = w_sig_b >> w_d;
      w_mask      = (27'd1 << w_d) - 27'd1;
      w_b_aligned = w_b_shift | {26'd0, |(w_sig_b & w_mask)};
    end
  end

  // ---------------- NORM: leading-zero count and exponent adjust ----------------
  logic [4:0]        w_lz;
  logic [25:0]       w_shl, w_norm;
  logic signed [9:0] w_nexp;

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (r_sum[i]) w_lz = 5'(26 - i);
    end
    w_shl = r_sum[25:0] << w_lz;
    if (r_sum[27]) begin
      w_norm = {r_sum[26:2], r_sum[1] | r_sum[0]};
      w_nexp = $signed({2'b00, r_exp}) + 10'sd1;
    end else begin
      w_norm = w_shl;
      w_nexp = $signed({2'b00, r_exp}) - $signed({5'd0, w_lz});
    end
  end

  // ---------------- ROUND: nearest-even, overflow to infinity ----------------
  logic              w_inc;
  logic [23:0]       w_frac_rnd;
  logic signed [9:0] w_exp_rnd;
  logic [31:0]       w_final;

  always_comb begin
    w_inc      = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    w_frac_rnd = {1'b0, r_norm[25:3]} + {23'd0, w_inc};
    // a carry out of the fraction means the significand became 10.000...
    w_exp_rnd  = r_nexp + (w_frac_rnd[23] ? 10'sd1 : 10'sd0);
    if (r_special)
      w_final = r_special_val;
    else if (r_nzero)
      w_final = {r_sign, 31'd0};
    else if (w_exp_rnd >= 10'sd255)
      w_final = {r_sign, c_inf_mag};
    else
      w_final = {r_sign, w_exp_rnd[7:0], w_frac_rnd[22:0]};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (start) w_next_state = c_st_align;
      c_st_align:  w_next_state = c_st_addsub;
      c_st_addsub: w_next_state = c_st_norm;
      c_st_norm:   w_next_state = c_st_round;
      c_st_round:  w_next_state = c_st_done;
      c_st_done:   w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  logic w_busy_nx, w_done_nx;

  always_comb begin
    w_busy_nx = (r_state == c_st_align) || (r_state == c_st_addsub) ||
                (r_state == c_st_norm)  || (r_state == c_st_round);
    w_done_nx = (r_state == c_st_done);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= 32'd0;  r_y <= 32'd0;  r_special <= 1'b0;  r_special_val <= 32'd0;
      r_sig_a <= 27'd0;  r_sig_b <= 27'd0;  r_exp <= 8'd0;
      r_sign <= 1'b0;  r_eff_sub <= 1'b0;  r_sum <= 28'd0;  r_sum_zero <= 1'b0;
      r_norm <= 26'd0;  r_nexp <= 10'sd0;  r_nzero <= 1'b0;  r_final <= 32'd0;
    end else begin
      case (r_state)
        c_st_idle: if (start) begin
          r_x           <= op1;
          r_y           <= w_op2n;
          r_special     <= w_spec;
          r_special_val <= w_spec_val;
        end
        c_st_align: begin
          r_sig_a   <= {1'b1, w_big[22:0], 3'b000};
          r_sig_b   <= w_b_aligned;
          r_exp     <= w_big[30:23];
          r_sign    <= w_big[31];
          r_eff_sub <= r_x[31] ^ r_y[31];
        end
        c_st_addsub: begin
          // the swap guarantees A >= B, so the difference never goes negative
          if (r_eff_sub) r_sum <= {1'b0, r_sig_a} - {1'b0, r_sig_b};
          else           r_sum <= {1'b0, r_sig_a} + {1'b0, r_sig_b};
          r_sum_zero <= r_eff_sub && (r_sig_a == r_sig_b);
          if (r_eff_sub && (r_sig_a == r_sig_b)) r_sign <= 1'b0;
        end
        c_st_norm: begin
          r_norm  <= w_norm;
          r_nexp  <= w_nexp;
          r_nzero <= r_sum_zero || (w_nexp <= 10'sd0);
        end
        c_st_round: r_final <= w_final;
        default: ;
      endcase
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= w_busy_nx;
      done <= w_done_nx;
      if (w_done_nx) result <= r_final;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpsubtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpsubtractor
// Purpose  : Self-checking bench for fpsubtractor: directed vector table,
//            randomized operands against an exact-arithmetic reference,
//            reset abort, ignored start pulses and back-to-back throughput.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpsubtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op1, op2;
  logic [31:0] result;
  logic        busy, done;

  fpsubtractor dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op1    (op1),
    .op2    (op2),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exact reference: the difference is formed as a wide integer and rounded
  // once to 24 significant bits, nearest-even.
  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic sa, sb, ts;
    int ea, eb, te, d, p, e, sh;
    longint unsigned ma, mb, tm, bx, by, diff, sig, rem, half;
    sa = x[31];  sb = ~y[31];
    ea = int'(x[30:23]);  eb = int'(y[30:23]);
    ma = {41'd0, x[22:0]};  mb = {41'd0, y[22:0]};
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
    if (ea == 255) return {sa, 8'hFF, 23'd0};
    if (eb == 255) return {sb, 8'hFF, 23'd0};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
    if (ea == 0) return {sb, y[30:0]};
    if (eb == 0) return x;
    if (ea < eb || (ea == eb && ma < mb)) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
    end
    d  = ea - eb;
    bx = (ma | (64'd1 << 23)) << 34;
    by = (d <= 34) ? (((mb | (64'd1 << 23)) << 34) >> d) : 64'd1;
    diff = (sa == sb) ? bx + by : bx - by;
    if (diff == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (diff[i]) p = i;
    e = ea + p - 57;
    if (e <= 0) return {sa, 31'd0};
    sh   = p - 23;
    sig  = diff >> sh;
    rem  = diff & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin sig = sig >> 1; e = e + 1; end
    if (e >= 255) return {sa, 8'hFF, 23'd0};
    return {sa, e[7:0], sig[22:0]};
  endfunction

  // One operation: single-cycle start, then watch for done within a bound.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int nbusy,
                       output int overlap);
    @(negedge clk);
    op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; nbusy = 0; overlap = 0; res = 32'hDEADBEEF;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (busy && done) overlap = 1;
      if (done) begin lat = k; res = result; break; end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] res, ra, rb;
  int          lat, nb, ov, n_done, mode, eb_i;
  int          done_at[$];

  initial begin
    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000};  // 3 - 1
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h40000000};  // 1 - (-1)
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h00000000};  // 1 - 1
    vecs[3]  = '{32'h80000000, 32'h00000000, 32'h80000000};  // -0 - +0
    vecs[4]  = '{32'h00000001, 32'h00000000, 32'h00000000};  // denormal flushed
    vecs[5]  = '{32'h3F800000, 32'h33800000, 32'h3F7FFFFF};  // 1 - 2^-24
    vecs[6]  = '{32'h3F800000, 32'h33000000, 32'h3F800000};  // tie to even
    vecs[7]  = '{32'h3F800000, 32'h2F800000, 32'h3F800000};  // sticky only
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000};  // inf - inf
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7F800000};  // inf - (-inf)
    vecs[10] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000};  // overflow
    vecs[11] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};  // NaN operand
    vecs[12] = '{32'h00000000, 32'h3F800000, 32'hBF800000};  // 0 - 1
    vecs[13] = '{32'h3F800000, 32'h00000000, 32'h3F800000};  // 1 - 0
    vecs[14] = '{32'h80000000, 32'h80000000, 32'h00000000};  // -0 - -0
    vecs[15] = '{32'h3F800000, 32'h7F800000, 32'hFF800000};  // 1 - inf
    vecs[16] = '{32'h40000000, 32'h3FC00000, 32'h3F000000};  // 2 - 1.5
    vecs[17] = '{32'hC0400000, 32'hBF800000, 32'hC0000000};  // -3 - -1

    reset = 1'b0; start = 1'b0; op1 = 32'd0; op2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_result", result, 32'd0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    @(negedge clk) reset = 1'b1;

    // directed table
    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, lat, nb, ov);
      check32($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check_int($sformatf("vec%0d_latency", i), lat, 5);
      check_int($sformatf("vec%0d_busy_cycles", i), nb, 4);
      check_int($sformatf("vec%0d_busy_done_overlap", i), ov, 0);
    end

    // randomized operands against the reference
    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 9);
      if (mode != 9) begin
        ra[30:23] = 8'($urandom_range(1, 254));
        eb_i = int'(ra[30:23]) - int'($urandom_range(0, 30));
        if (eb_i < 1) eb_i = 1;
        rb[30:23] = (mode < 6) ? eb_i[7:0] : 8'($urandom_range(1, 254));
        if (mode == 4) rb[30:0] = ra[30:0];
        if (mode == 5) rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 7));
      end
      do_op(ra, rb, res, lat, nb, ov);
      check32($sformatf("rand%0d_%08h_%08h", n, ra, rb), res, ref_sub(ra, rb));
      check_int($sformatf("rand%0d_latency", n), lat, 5);
    end

    // reset during ADDSUB aborts the operation
    @(negedge clk);
    op1 = 32'h40400000; op2 = 32'h3F800000; start = 1'b1;
    @(posedge clk);                 // capture
    #1 start = 1'b0;
    @(posedge clk);                 // now in ADDSUB
    #3 reset = 1'b0;
    #1;
    check32("abort_result", result, 32'd0);
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    #10 reset = 1'b1;
    n_done = 0;
    repeat (8) begin @(posedge clk); #1; if (done) n_done++; end
    check_int("abort_no_done", n_done, 0);
    do_op(32'h40400000, 32'h3F800000, res, lat, nb, ov);
    check32("after_abort_result", res, 32'h40000000);
    check_int("after_abort_latency", lat, 5);

    // start pulses during busy and during DONE are ignored
    @(negedge clk);
    op1 = 32'h40400000; op2 = 32'h3F800000; start = 1'b1;
    @(posedge clk);                 // capture, edge E
    #1 start = 1'b0;
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h3F800000; start = 1'b1;
    @(posedge clk);                 // E+1, ALIGN
    #1 start = 1'b0;
    repeat (3) @(posedge clk);      // E+4, entering DONE
    @(negedge clk) start = 1'b1;
    @(posedge clk);                 // E+5, sampled in DONE
    #1 start = 1'b0;
    check_int("ignore_done_pulse", int'(done), 1);
    check32("ignore_result", result, 32'h40000000);
    n_done = 0;
    repeat (10) begin @(posedge clk); #1; if (done) n_done++; end
    check_int("ignore_extra_done", n_done, 0);

    // start held high: one capture every 6 cycles
    @(negedge clk);
    op1 = 32'h40400000; op2 = 32'h3F800000; start = 1'b1;
    @(posedge clk);                 // first capture, k = 0
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (done) done_at.push_back(k);
    end
    start = 1'b0;
    check_int("held_done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      check_int("held_first_done", done_at[0], 5);
      check_int("held_spacing0", done_at[1] - done_at[0], 6);
      check_int("held_spacing1", done_at[2] - done_at[1], 6);
    end
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
